// File: rtl/switch_clock_monitor_if.sv
// Measurement result bundle produced by switch_clock_monitor.
//   period_count : last measured switch clock period, clk cycles
//   high_count   : last measured high time, clk cycles
//   meas_valid   : one-cycle pulse when period_count/high_count update
//   locked       : enough consecutive in-tolerance measurements seen
//   timeout      : no rising edge seen for the timeout window
// master = the monitor driving results, slave = any consumer.
interface switch_clock_monitor_if #(
    parameter int CNT_W = 20
);
    logic [CNT_W-1:0] period_count;
    logic [CNT_W-1:0] high_count;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output period_count,
        output high_count,
        output meas_valid,
        output locked,
        output timeout
    );

    modport slave (
        input period_count,
        input high_count,
        input meas_valid,
        input locked,
        input timeout
    );
endinterface

// File: rtl/switch_clock_monitor.sv
// Receive-side checker for the looped-back switch clock. The pin is
// synchronised into the clk domain, and its period and high time are measured
// in clk cycles. Each completed period is reported, lock is declared after
// LOCK_COUNT consecutive in-tolerance periods, and loss of signal is flagged.
//
// Ports:
//   clk       : system clock
//   rst       : synchronous, active-high reset
//   sw_clk_in : asynchronous looped-back switch clock
//   mon       : result bundle (period_count, high_count, meas_valid,
//               locked, timeout), master side
//
// States:
//   state     | meaning
//   ----------+------------------------------------------------------------
//   WAIT_EDGE | unarmed; the next rise only starts a measurement
//   MEASURE   | armed; each rise closes a period and reports it
module switch_clock_monitor #(
    parameter int CNT_W           = 20,
    parameter int EXPECTED_PERIOD = 48000,
    parameter int EXPECTED_HIGH   = 24000,
    parameter int TOLERANCE       = 48,
    parameter int LOCK_COUNT      = 4,
    parameter int TIMEOUT         = 96000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sw_clk_in,
    switch_clock_monitor_if.master mon
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [GOOD_W-1:0] LOCK_VAL    = GOOD_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT);

    // Acceptance windows are held one bit wider than the counters and clamped
    // at zero so that the ordered compare can never wrap.
    localparam logic [CNT_W:0] PERIOD_LO = (EXPECTED_PERIOD > TOLERANCE) ?
                                           (CNT_W+1)'(EXPECTED_PERIOD - TOLERANCE) : '0;
    localparam logic [CNT_W:0] PERIOD_HI = (CNT_W+1)'(EXPECTED_PERIOD + TOLERANCE);
    localparam logic [CNT_W:0] HIGH_LO   = (EXPECTED_HIGH > TOLERANCE) ?
                                           (CNT_W+1)'(EXPECTED_HIGH - TOLERANCE) : '0;
    localparam logic [CNT_W:0] HIGH_HI   = (CNT_W+1)'(EXPECTED_HIGH + TOLERANCE);

    typedef enum logic {
        WAIT_EDGE = 1'b0,
        MEASURE   = 1'b1
    } state_t;

    state_t              state;
    logic                s1;
    logic                s2;
    logic                s3;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    high_latch;
    logic [GOOD_W-1:0]   good_cnt;
    logic [CNT_W-1:0]    period_q;
    logic [CNT_W-1:0]    high_q;
    logic                meas_valid_q;
    logic                locked_q;
    logic                timeout_q;

    logic                rise;
    logic                fall;
    logic                period_good;
    logic                high_good;
    logic                meas_good;
    logic [GOOD_W-1:0]   good_nxt;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // cnt is the period being closed on a rise cycle; a saturated cnt sits far
    // above PERIOD_HI and is therefore always judged bad.
    assign period_good = ({1'b0, cnt} >= PERIOD_LO) && ({1'b0, cnt} <= PERIOD_HI);
    assign high_good   = ({1'b0, high_latch} >= HIGH_LO) && ({1'b0, high_latch} <= HIGH_HI);
    assign meas_good   = period_good & high_good;

    assign good_nxt = (good_cnt == LOCK_VAL) ? LOCK_VAL : good_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_EDGE;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            cnt          <= '0;
            high_latch   <= '0;
            good_cnt     <= '0;
            period_q     <= '0;
            high_q       <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            s1 <= sw_clk_in;
            s2 <= s1;
            s3 <= s2;

            meas_valid_q <= 1'b0;

            // Elapsed cycles since the last rise; runs in every state.
            if (rise) begin
                cnt <= CNT_ONE;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (fall && state == MEASURE) begin
                high_latch <= cnt;
            end

            if (rise) begin
                // A rise always ends loss of signal; in WAIT_EDGE it only arms.
                timeout_q <= 1'b0;
                if (state == WAIT_EDGE) begin
                    state <= MEASURE;
                end else begin
                    period_q     <= cnt;
                    high_q       <= high_latch;
                    meas_valid_q <= 1'b1;
                    if (meas_good) begin
                        good_cnt <= good_nxt;
                        locked_q <= (good_nxt == LOCK_VAL);
                    end else begin
                        good_cnt <= '0;
                        locked_q <= 1'b0;
                    end
                end
            end else if (cnt == TIMEOUT_VAL) begin
                // Results are kept so the last good reading stays visible.
                timeout_q <= 1'b1;
                locked_q  <= 1'b0;
                good_cnt  <= '0;
                state     <= WAIT_EDGE;
            end
        end
    end

    assign mon.period_count = period_q;
    assign mon.high_count   = high_q;
    assign mon.meas_valid   = meas_valid_q;
    assign mon.locked       = locked_q;
    assign mon.timeout      = timeout_q;

endmodule

// File: tb/tb_switch_clock_monitor.sv
// Directed bench for switch_clock_monitor, run with a scaled-down timebase
// (period 480, high 240, tolerance 48, timeout 960) so every scenario fits in
// a short run. Expected values are worked out by hand from the stimulus.
module tb_switch_clock_monitor;

    localparam int CW  = 12;
    localparam int PER = 480;
    localparam int HI  = 240;
    localparam int TOL = 48;
    localparam int LCK = 4;
    localparam int TMO = 960;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_clk_in = 1'b0;

    switch_clock_monitor_if #(.CNT_W(CW)) mon_if ();

    switch_clock_monitor #(
        .CNT_W           (CW),
        .EXPECTED_PERIOD (PER),
        .EXPECTED_HIGH   (HI),
        .TOLERANCE       (TOL),
        .LOCK_COUNT      (LCK),
        .TIMEOUT         (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_clk_in (sw_clk_in),
        .mon       (mon_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    int mv_count    = 0;
    int last_period = 0;
    int last_high   = 0;
    int last_locked = 0;
    bit to_seen     = 1'b0;
    int to_cyc      = 0;
    int rise_cyc    = 0;
    int mv_before   = 0;

    always @(negedge clk) begin
        if (mon_if.meas_valid) begin
            mv_count++;
            last_period = int'(mon_if.period_count);
            last_high   = int'(mon_if.high_count);
            last_locked = int'(mon_if.locked);
        end
        if (mon_if.timeout && !to_seen) begin
            to_seen = 1'b1;
            to_cyc  = cyc;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gen_cycle(input int hi, input int lo);
        sw_clk_in = 1'b1;
        rise_cyc  = cyc;
        tick(hi);
        sw_clk_in = 1'b0;
        tick(lo);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, int'(mon_if.period_count), 0);
        check({tag, "_high"},   int'(mon_if.high_count),   0);
        check({tag, "_mv"},     int'(mon_if.meas_valid),   0);
        check({tag, "_locked"}, int'(mon_if.locked),       0);
        check({tag, "_tmo"},    int'(mon_if.timeout),      0);
    endtask

    initial begin
        rst = 1'b1;
        sw_clk_in = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // Ideal source: first rise only arms, lock on the 4th measurement.
        gen_cycle(240, 240);
        check("ideal_arm_only", mv_count, 0);
        for (int k = 2; k <= 5; k++) begin
            gen_cycle(240, 240);
            check("ideal_mv_count", mv_count, k - 1);
            check("ideal_period", last_period, 480);
            check("ideal_high", last_high, 240);
            check("ideal_locked", last_locked, (k == 5) ? 1 : 0);
            check("ideal_timeout", int'(mon_if.timeout), 0);
        end

        // Tolerance edge: 528 keeps lock, 529 drops it, 4 goods to relock.
        gen_cycle(240, 288);
        gen_cycle(240, 289);
        check("tol_528_period", last_period, 528);
        check("tol_528_locked", last_locked, 1);
        gen_cycle(240, 240);
        check("tol_529_period", last_period, 529);
        check("tol_529_locked", last_locked, 0);
        for (int j = 1; j <= 4; j++) begin
            gen_cycle(240, 240);
            check("tol_relock", last_locked, (j == 4) ? 1 : 0);
        end

        // Loss of signal: hold low until timeout asserts.
        mv_before = mv_count;
        to_seen = 1'b0;
        for (int i = 0; i < 2000 && !to_seen; i++) tick(1);
        check("los_timeout_seen", int'(to_seen), 1);
        check("los_latency", to_cyc - rise_cyc, TMO + 3);
        check("los_locked", int'(mon_if.locked), 0);
        check("los_no_meas", mv_count, mv_before);
        check("los_period_hold", int'(mon_if.period_count), 480);
        gen_cycle(240, 240);
        check("los_resume_arm", mv_count, mv_before);
        check("los_resume_tmo", int'(mon_if.timeout), 0);
        gen_cycle(240, 240);
        check("los_resume_mv", mv_count, mv_before + 1);
        check("los_resume_period", last_period, 480);
        check("los_resume_high", last_high, 240);
        check("los_resume_locked", last_locked, 0);
        for (int j = 0; j < 3; j++) gen_cycle(240, 240);
        check("los_relocked", int'(mon_if.locked), 1);

        // Reset 100 cycles into a high phase; input still high at release.
        sw_clk_in = 1'b1;
        rise_cyc = cyc;
        tick(100);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_all_zero("midrst");
        mv_before = mv_count;
        tick(139);
        sw_clk_in = 1'b0;
        tick(240);
        check("midrst_arm_only", mv_count, mv_before);
        gen_cycle(300, 180);
        check("midrst_mv", mv_count, mv_before + 1);
        check("midrst_period", last_period, 379);
        check("midrst_high", last_high, 139);
        check("midrst_locked", last_locked, 0);

        // Duty skew: right period, high time 60 out.
        for (int j = 0; j < 4; j++) begin
            gen_cycle(300, 180);
            check("skew_period", last_period, 480);
            check("skew_high", last_high, 300);
            check("skew_locked", last_locked, 0);
        end

        // Off-frequency source from a fresh reset.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        mv_before = mv_count;
        gen_cycle(300, 300);
        check("offf_arm_only", mv_count, mv_before);
        for (int j = 0; j < 4; j++) begin
            gen_cycle(300, 300);
            check("offf_period", last_period, 600);
            check("offf_high", last_high, 300);
            check("offf_locked", last_locked, 0);
        end
        check("offf_mv_total", mv_count, mv_before + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
